mult_hilo_ctrl: RTL and testbench

Sequencer for the iterative multiply unit and the HI/LO register pair in the pipelined MIPS core.
- Accepts a mult issue from EX and runs a shift-add multiply over WIDTH cycles.
- Writes the 2*WIDTH-bit product into HI/LO.
- Serves mfhi/mflo reads and raises a pipeline stall while a read or new mult would hit an in-flight multiply.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mult_shift_add.sv | 131 +++++++++++++
 rtl/mult_hilo_ctrl.sv | 154 +++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipelined MIPS core:
//   - ALU control codes decoded in EX (add, sub, ..., mult, mfhi, mflo)
//   - mult_state_t, the state set of the iterative multiply sequencer
//   - MULT_WIDTH_DEF, default operand width of the multiply unit
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int MULT_WIDTH_DEF = 32;

    // ALU control codes presented by the decode stage
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_MULT = 4'd5;
    localparam logic [3:0] ALU_MFHI = 4'd6;
    localparam logic [3:0] ALU_MFLO = 4'd7;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add.sv
// ---------------------------------------------------------------------------
// mult_shift_add
// Datapath of the iterative multiplier: multiplicand / multiplier shift
// registers, 2*WIDTH accumulator and the adder between them.
//   clk       in   core clock
//   rst_n     in   synchronous active-low reset, clears all state
//   load      in   latch operands, clear accumulator
//   step      in   perform one shift-add iteration
//   op_a      in   multiplicand (WIDTH)
//   op_b      in   multiplier   (WIDTH)
//   prod_next out  accumulator value after the current step (2*WIDTH),
//                  sign-corrected when signed multiply is built in
// Build option: SIGNED_MULT_EN -- operands are two's complement; their
// magnitudes are multiplied and the result is negated on the way out.
// ---------------------------------------------------------------------------
module mult_shift_add
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   prod_next
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;

`ifdef SIGNED_MULT_EN
    logic neg_q, neg_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        // most-negative value maps onto itself, which is still correct as unsigned
        if (v[WIDTH-1]) begin
            return ~v + WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    // operand magnitudes for the unsigned core
    always_comb begin
        a_mag_s = magnitude(op_a);
        b_mag_s = magnitude(op_b);
    end

    // result sign is captured together with the operands
    always_comb begin
        if (load) begin
            neg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end else begin
            neg_d = neg_q;
        end
    end

    // negate the magnitude product when operand signs differ
    always_comb begin
        if (neg_q) begin
            prod_next = ~acc_step_s + (2*WIDTH)'(1);
        end else begin
            prod_next = acc_step_s;
        end
    end

    // result-sign register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`else
    // unsigned build: operands feed the core directly
    always_comb begin
        a_mag_s   = op_a;
        b_mag_s   = op_b;
        prod_next = acc_step_s;
    end
`endif

    // accumulator value if the current iteration were committed
    always_comb begin
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
    end

    // load / step next-state for the shift registers and accumulator
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag_s};
            mplier_d = b_mag_s;
            acc_d    = {(2*WIDTH){1'b0}};
        end else if (step) begin
            acc_d    = acc_step_s;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end else begin
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
            acc_d    = acc_q;
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// mult_hilo_ctrl
// Sequencer for the iterative multiply unit plus the HI/LO register pair.
// A mult issued from EX runs WIDTH shift-add iterations; the product is
// written to {hi,lo} on the RUN->DONE edge. mfhi/mflo reads and new mults
// that would collide with a running multiply stall the front of the pipe.
//   clk      in   core clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   mult issue (one-cycle pulse)
//   op_a     in   multiplicand (WIDTH)
//   op_b     in   multiplier   (WIDTH)
//   rd_hi    in   mfhi in EX
//   rd_lo    in   mflo in EX
//   flush    in   abort in-flight multiply / suppress start
//   busy     out  multiply in progress
//   stall    out  freeze IF/ID/EX
//   done     out  one-cycle pulse, product committed
//   hi, lo   out  HI/LO registers (WIDTH each)
//   rd_data  out  mfhi/mflo read data, rd_hi has priority
// Build option: SIGNED_MULT_EN -- two's-complement multiply (see
// mult_shift_add); latency is the same as the unsigned build.
// ---------------------------------------------------------------------------
module mult_hilo_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = MULT_IDLE;
    localparam logic [1:0] S_RUN  = MULT_RUN;
    localparam logic [1:0] S_DONE = MULT_DONE;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_s, step_s;
    logic [2*WIDTH-1:0] prod_next_s;

    mult_shift_add #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .step      (step_s),
        .op_a      (op_a),
        .op_b      (op_b),
        .prod_next (prod_next_s)
    );

    // FSM next state, iteration counter and HI/LO commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start directly so mults can run back to back
                if (start && !flush) begin
                    load_s  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    step_s = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // last iteration: commit the post-step product on this edge
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        hi_d    = prod_next_s[2*WIDTH-1:WIDTH];
                        lo_d    = prod_next_s[WIDTH-1:0];
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        busy_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // control and HI/LO registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // read mux; in DONE hi_q/lo_q already hold the fresh product
    always_comb begin
        if (rd_hi) begin
            rd_data = hi_q;
        end else if (rd_lo) begin
            rd_data = lo_q;
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

    // a start seen in RUN is held upstream and re-presented, never queued here
    assign stall = (state_q == S_RUN) & (start | rd_hi | rd_lo);
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
module tb_mult_hilo_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         rd_hi = 1'b0;
    logic         rd_lo = 1'b0;
    logic         flush = 1'b0;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo, rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    mult_hilo_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .flush(flush),
        .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference product straight from the arithmetic definition
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_MULT_EN
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
`else
        logic [2*W-1:0] ua, ub;
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
`endif
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // waits for done; n0 = negedges already spent since the start edge
    task automatic expect_result(input string name, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int n0);
        logic [2*W-1:0] p;
        int n, nbusy;
        bit seen, held_bad;
        p = ref_mul(a, b);
        n = n0; nbusy = n0; seen = 0; held_bad = 0;
        while (!seen && n < 80) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (busy === 1'b1) nbusy++;
                if (hi !== exp_hi || lo !== exp_lo) held_bad = 1;
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL %s_done: done never seen within %0d cycles", name, n); end
        n_checks++;
        if (n != W + 1) begin n_fail++; $display("FAIL %s_latency: got %0d cycles, expected %0d", name, n, W + 1); end
        n_checks++;
        if (nbusy != W) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, nbusy, W); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_in_done: got %b, expected 0", name, busy); end
        n_checks++;
        if (held_bad) begin n_fail++; $display("FAIL %s_hilo_held: hi/lo changed before done, expected %h/%h", name, exp_hi, exp_lo); end
        n_checks++;
        if (hi !== p[2*W-1:W]) begin n_fail++; $display("FAIL %s_hi: got %h, expected %h", name, hi, p[2*W-1:W]); end
        n_checks++;
        if (lo !== p[W-1:0]) begin n_fail++; $display("FAIL %s_lo: got %h, expected %h", name, lo, p[W-1:0]); end
        exp_hi = p[2*W-1:W];
        exp_lo = p[W-1:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; rd_lo = 1'b0; rd_hi = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, stall, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: busy/stall/done=%b, expected 000", {busy, stall, done}); end
        n_checks++;
        if (hi !== '0 || lo !== '0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h, expected 0/0", hi, lo); end
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd: got %h, expected 0", rd_data); end
        rd_hi = 1'b0;
        exp_hi = '0; exp_lo = '0;
        idle_cycle();
    endtask

    task automatic test_basic();
        issue(32'd3, 32'd5);
        expect_result("basic", 32'd3, 32'd5, 0);
        idle_cycle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_result("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle_cycle();
        issue(32'hFFFF_FFFE, 32'd3);
        expect_result("sign_case", 32'hFFFF_FFFE, 32'd3, 0);
        idle_cycle();
    endtask

    task automatic test_read_stall();
        logic [W-1:0] a, b;
        logic [2*W-1:0] p;
        int n, nrun;
        bit seen, stall_bad;
        a = 32'hDEAD_BEEF;
        b = $urandom | 32'h8000_0000;
        p = ref_mul(a, b);
        issue(a, b);
        rd_hi = 1'b1;
        n = 0; nrun = 0; seen = 0; stall_bad = 0;
        while (!seen && n < 80) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1;
            else begin
                nrun++;
                if (stall !== 1'b1) stall_bad = 1;
            end
        end
        n_checks++;
        if (stall_bad || nrun != W) begin n_fail++; $display("FAIL rd_stall_run: stall dropped or run length %0d, expected %0d", nrun, W); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL rd_stall_done: got %b, expected 0", stall); end
        n_checks++;
        if (rd_data !== p[2*W-1:W]) begin n_fail++; $display("FAIL rd_hi_data: got %h, expected %h", rd_data, p[2*W-1:W]); end
        rd_lo = 1'b1; #1;
        n_checks++;
        if (rd_data !== p[2*W-1:W]) begin n_fail++; $display("FAIL rd_priority: got %h, expected %h", rd_data, p[2*W-1:W]); end
        rd_hi = 1'b0; #1;
        n_checks++;
        if (rd_data !== p[W-1:0]) begin n_fail++; $display("FAIL rd_lo_data: got %h, expected %h", rd_data, p[W-1:0]); end
        rd_lo = 1'b0; #1;
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL rd_none: got %h, expected 0", rd_data); end
        exp_hi = p[2*W-1:W];
        exp_lo = p[W-1:0];
        idle_cycle();
    endtask

    task automatic test_start_in_run();
        logic [W-1:0] a1, b1;
        a1 = $urandom; b1 = $urandom;
        issue(a1, b1);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1; op_a = $urandom; op_b = $urandom;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL start_in_run_stall: got %b, expected 1", stall); end
        @(posedge clk); #1;
        start = 1'b0;
        expect_result("start_in_run", a1, b1, 3);
        idle_cycle();
    endtask

    task automatic test_flush();
        int nd;
        issue(32'd3, 32'd5);
        expect_result("pre_flush", 32'd3, 32'd5, 0);
        idle_cycle();
        issue($urandom | 32'h1, $urandom | 32'h1);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_idle: busy/done=%b%b, expected 00", busy, done); end
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        n_checks++;
        if (nd != 0) begin n_fail++; $display("FAIL flush_no_done: %0d active cycles, expected 0", nd); end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd15) begin n_fail++; $display("FAIL flush_hilo: got %h/%h, expected 0/f", hi, lo); end
        start = 1'b1; flush = 1'b1; op_a = 32'd7; op_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_start: busy=%b, expected 0", busy); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        issue(a1, b1);
        expect_result("b2b_first", a1, b1, 0);
        issue(a2, b2);
        expect_result("b2b_second", a2, b2, 0);
        idle_cycle();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int gap;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            if (i == 2) a = 32'h8000_0000;
            if (i == 3) b = 32'd0;
            issue(a, b);
            expect_result($sformatf("rand%0d", i), a, b, 0);
            gap = $urandom_range(0, 2);
            repeat (gap) idle_cycle();
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_run();
        int nd;
        issue($urandom | 32'h1, $urandom | 32'h1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0; rd_hi = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, stall, done} !== 3'b000) begin n_fail++; $display("FAIL midrun_reset_ctrl: busy/stall/done=%b, expected 000", {busy, stall, done}); end
        n_checks++;
        if (hi !== '0 || lo !== '0) begin n_fail++; $display("FAIL midrun_reset_hilo: got %h/%h, expected 0/0", hi, lo); end
        rd_hi = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        n_checks++;
        if (nd != 0) begin n_fail++; $display("FAIL midrun_reset_no_done: %0d done pulses, expected 0", nd); end
        exp_hi = '0; exp_lo = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read_stall();
        test_start_in_run();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
